// File: rtl/eeprom_arb_pkg.sv
// rtl/eeprom_arb_pkg.sv - shared types and widths for the EEPROM request arbiter
package eeprom_arb_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_ACK = 3'd2,
    TWR      = 3'd3,
    RECOVER  = 3'd4
  } state_t;

  // Counter width that stays legal when the count parameter is 0 or 1
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eeprom_req_arbiter_rr.sv
// rtl/eeprom_req_arbiter_rr.sv - combinational round-robin pick starting after the last grant
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      c = (int'(last) + k) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDXW'(c);
      end
    end
  end

endmodule

// File: rtl/eeprom_req_arbiter.sv
// rtl/eeprom_req_arbiter.sv - round-robin sharing of one serial-EEPROM byte engine with write-cycle hold-off and timeout recovery
module eeprom_req_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TWR_CYC     = 10000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_wr,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_gnt,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     eng_wr,
  output logic                     eng_rd,
  output logic [ADDR_W-1:0]        eng_addr,
  output logic [DATA_W-1:0]        eng_data_o,
  output logic                     eng_data_oe,
  input  logic [DATA_W-1:0]        eng_data_i,
  input  logic                     eng_ack,
  output logic                     eng_rst
);

  localparam int IDXW = $clog2(NREQ);
  localparam int TO_W = cnt_w(TIMEOUT_CYC);
  localparam int TW_W = cnt_w(TWR_CYC);

  state_t          state;
  logic [TO_W-1:0] tcnt;
  logic [TW_W-1:0] twcnt;
  logic            rcnt;
  logic            cur_wr;
  logic [IDXW-1:0] last_grant;

  logic [NREQ-1:0] pick_gnt;
  logic [IDXW-1:0] pick_idx;
  logic            pick_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      tcnt        <= '0;
      twcnt       <= '0;
      rcnt        <= 1'b0;
      cur_wr      <= 1'b0;
      last_grant  <= IDXW'(NREQ - 1);
      req_gnt     <= '0;
      req_done    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      eng_wr      <= 1'b0;
      eng_rd      <= 1'b0;
      eng_addr    <= '0;
      eng_data_o  <= '0;
      eng_data_oe <= 1'b0;
      eng_rst     <= 1'b0;
    end else begin
      req_done <= '0;
      eng_wr   <= 1'b0;
      eng_rd   <= 1'b0;
      case (state)
        IDLE: begin
          // Strobe is registered at grant so it lands in the ISSUE cycle
          if (pick_any) begin
            req_gnt     <= pick_gnt;
            last_grant  <= pick_idx;
            cur_wr      <= req_wr[pick_idx];
            eng_wr      <= req_wr[pick_idx];
            eng_rd      <= !req_wr[pick_idx];
            eng_addr    <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            eng_data_o  <= req_wdata[pick_idx*DATA_W +: DATA_W];
            eng_data_oe <= req_wr[pick_idx];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // ACK is checked first so it wins over a coincident timeout
          if (eng_ack) begin
            if (!cur_wr) rsp_rdata <= eng_data_i;
            req_done    <= req_gnt;
            rsp_err     <= 1'b0;
            req_gnt     <= '0;
            eng_data_oe <= 1'b0;
            twcnt       <= '0;
            state       <= (cur_wr && (TWR_CYC > 0)) ? TWR : IDLE;
          end else if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
            eng_rst <= 1'b1;
            rcnt    <= 1'b0;
            state   <= RECOVER;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RECOVER: begin
          if (!rcnt) begin
            rcnt        <= 1'b1;
            req_done    <= req_gnt;
            rsp_err     <= 1'b1;
            req_gnt     <= '0;
            eng_data_oe <= 1'b0;
          end else begin
            eng_rst <= 1'b0;
            state   <= IDLE;
          end
        end
        TWR: begin
          if (twcnt == TW_W'(TWR_CYC - 1)) state <= IDLE;
          else                             twcnt <= twcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
